// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: iterative restoring integer divider with a run-time signed/unsigned
// mode. It works on operand magnitudes and resolves BITS_PER_CYCLE quotient
// bits per clock. A sign fixup at the end gives truncating (C-style) division.
// The result is presented in HI/LO layout as {remainder, quotient}.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           synchronous reset, active-low
//   signed_div_i  1 = signed divide, 0 = unsigned divide
//   opdata1_i     dividend (WIDTH bits)
//   opdata2_i     divisor (WIDTH bits)
//   start_i       request; held high by EX until the result is consumed
//   annul_i       abort from the flush path; honoured in every non-idle state
//   result_o      {remainder, quotient} (2*WIDTH bits, registered)
//   ready_o       result_o valid (registered)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BY_ZERO,
        DIV_ON,
        DIV_END
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  rem;       // partial remainder
    logic [WIDTH-1:0]  quo;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  dsr;       // divisor magnitude
    logic              sgn_mode;
    logic              dvd_neg;
    logic              dsr_neg;
    logic [2*WIDTH-1:0] step;     // {rem, quo} after one iteration

    // Two's-complement magnitude when the operand is negative.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. Because rem < dsr on entry, the trial
    // value fits in WIDTH+1 bits and bit WIDTH of the difference is the borrow.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r_in,
                                                    input logic [WIDTH-1:0] q_in,
                                                    input logic [WIDTH-1:0] d_in);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {r_in, q_in[WIDTH-1]};
        diff  = trial - {1'b0, d_in};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], q_in[WIDTH-2:0], 1'b1};
        else
            return {trial[WIDTH-1:0], q_in[WIDTH-2:0], 1'b0};
    endfunction

    // Quotient is negated when the operand signs differ; the remainder follows
    // the dividend. The most-negative / -1 case wraps back to most-negative.
    function automatic logic [2*WIDTH-1:0] fixup(input logic [WIDTH-1:0] r_in,
                                                 input logic [WIDTH-1:0] q_in,
                                                 input logic mode,
                                                 input logic n_dvd,
                                                 input logic n_dsr);
        logic [WIDTH-1:0] r_out;
        logic [WIDTH-1:0] q_out;
        r_out = (mode && n_dvd)           ? (~r_in + 1'b1) : r_in;
        q_out = (mode && (n_dvd ^ n_dsr)) ? (~q_in + 1'b1) : q_in;
        return {r_out, q_out};
    endfunction

    always_comb begin
        step = div_step(rem, quo, dsr);
        if (BITS_PER_CYCLE == 2)
            step = div_step(step[2*WIDTH-1:WIDTH], step[WIDTH-1:0], dsr);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= DIV_FREE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            DIV_FREE: begin
                if (start_i && !annul_i)
                    state_n = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: begin
                state_n = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i)
                    state_n = DIV_FREE;
                else if (cnt == CNT_LAST)
                    state_n = DIV_END;
            end
            DIV_END: begin
                if (!start_i || annul_i)
                    state_n = DIV_FREE;
            end
            default: state_n = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            sgn_mode <= 1'b0;
            dvd_neg  <= 1'b0;
            dsr_neg  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        cnt      <= '0;
                        rem      <= '0;
                        sgn_mode <= signed_div_i;
                        dvd_neg  <= opdata1_i[WIDTH-1];
                        dsr_neg  <= opdata2_i[WIDTH-1];
                        quo      <= mag(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
                        dsr      <= mag(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);
                    end
                end
                DIV_BY_ZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        if (cnt == CNT_LAST) begin
                            result_o <= fixup(rem, quo, sgn_mode, dvd_neg, dsr_neg);
                            ready_o  <= 1'b1;
                        end else begin
                            {rem, quo} <= step;
                            cnt        <= cnt + CW'(1);
                        end
                    end
                end
                DIV_END: begin
                    if (!start_i || annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
